// File: rtl/issue_queue.sv
// Issue-queue entry array feeding age_schedule: holds uops until sources are ready, launches selected ones.
// Optional IQ_WAKEUP_BYPASS_EN: same-cycle wakeups reach o_req_vld combinationally.
module issue_queue #(
  parameter int DEPTH     = 6,
  parameter int INPORTS   = 2,
  parameter int OUTS      = 2,
  parameter int WKPORTS   = 4,
  parameter int SRCS      = 2,
  parameter int PRF_W     = 7,
  parameter int PAYLOAD_W = 32,
  parameter int ROB_W     = 8,
  localparam int IDX_W    = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     i_flush,
  input  logic [INPORTS-1:0]                       i_enq_vld,
  output logic                                     o_enq_rdy,
  input  logic [INPORTS-1:0][ROB_W-1:0]            i_enq_robIdx,
  input  logic [INPORTS-1:0][SRCS-1:0][PRF_W-1:0]  i_enq_prs,
  input  logic [INPORTS-1:0][SRCS-1:0]             i_enq_prs_rdy,
  input  logic [INPORTS-1:0][PAYLOAD_W-1:0]        i_enq_payload,
  input  logic [WKPORTS-1:0]                       i_wk_vld,
  input  logic [WKPORTS-1:0][PRF_W-1:0]            i_wk_prd,
  output logic [DEPTH-1:0]                         o_req_vld,
  output logic [DEPTH-1:0][ROB_W-1:0]              o_req_ages,
  input  logic [OUTS-1:0]                          i_sel_vld,
  input  logic [OUTS-1:0][IDX_W-1:0]               i_sel_idx,
  input  logic [OUTS-1:0]                          i_iss_rdy,
  output logic [OUTS-1:0]                          o_iss_vld,
  output logic [OUTS-1:0][ROB_W-1:0]               o_iss_robIdx,
  output logic [OUTS-1:0][SRCS-1:0][PRF_W-1:0]     o_iss_prs,
  output logic [OUTS-1:0][PAYLOAD_W-1:0]           o_iss_payload,
  output logic [CNT_W-1:0]                         o_free_cnt
);
  localparam int PSEL_W = (INPORTS > 1) ? $clog2(INPORTS) : 1;

  logic [DEPTH-1:0]                        r_valid;
  logic [DEPTH-1:0][SRCS-1:0]              r_rdy;
  logic [DEPTH-1:0][ROB_W-1:0]             r_rob;
  logic [DEPTH-1:0][SRCS-1:0][PRF_W-1:0]   r_prs;
  logic [DEPTH-1:0][PAYLOAD_W-1:0]         r_pay;
  logic [CNT_W-1:0]                        r_free_cnt;
  logic [OUTS-1:0]                         r_iss_vld;
  logic [OUTS-1:0][ROB_W-1:0]              r_iss_rob;
  logic [OUTS-1:0][SRCS-1:0][PRF_W-1:0]    r_iss_prs;
  logic [OUTS-1:0][PAYLOAD_W-1:0]          r_iss_pay;

  logic [INPORTS-1:0]                      w_enq_go;
  logic [INPORTS-1:0]                      w_enq_found;
  logic [DEPTH-1:0]                        w_enq_we;
  logic [DEPTH-1:0][PSEL_W-1:0]            w_enq_port;
  logic [INPORTS-1:0][SRCS-1:0]            w_enq_src_rdy;
  logic [DEPTH-1:0][SRCS-1:0]              w_wk_src;
  logic [DEPTH-1:0][SRCS-1:0]              w_src_ok;
  logic [OUTS-1:0]                         w_sel_req;
  logic [OUTS-1:0]                         w_dup;
  logic [OUTS-1:0]                         w_fire;
  logic [DEPTH-1:0]                        w_iss_clr;
  logic [DEPTH-1:0]                        w_valid_nxt;
  logic [CNT_W-1:0]                        w_pop;

  assign o_enq_rdy     = (r_free_cnt >= CNT_W'(INPORTS));
  assign o_free_cnt    = r_free_cnt;
  assign o_iss_vld     = r_iss_vld;
  assign o_iss_robIdx  = r_iss_rob;
  assign o_iss_prs     = r_iss_prs;
  assign o_iss_payload = r_iss_pay;

  // Ports are packed onto the lowest registered-free entries, so a freed slot waits one cycle.
  always_comb begin
    w_enq_go    = i_enq_vld & {INPORTS{o_enq_rdy & ~i_flush}};
    w_enq_found = '0;
    w_enq_we    = '0;
    w_enq_port  = '0;
    for (int k = 0; k < INPORTS; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_enq_go[k] && !w_enq_found[k] && !r_valid[i] && !w_enq_we[i]) begin
          w_enq_found[k] = 1'b1;
          w_enq_we[i]    = 1'b1;
          w_enq_port[i]  = PSEL_W'(k);
        end
      end
    end
  end

  always_comb begin
    w_wk_src      = '0;
    w_enq_src_rdy = i_enq_prs_rdy;
    for (int w = 0; w < WKPORTS; w++) begin
      for (int s = 0; s < SRCS; s++) begin
        for (int i = 0; i < DEPTH; i++)
          if (i_wk_vld[w] && i_wk_prd[w] == r_prs[i][s]) w_wk_src[i][s] = 1'b1;
        for (int k = 0; k < INPORTS; k++)
          if (i_wk_vld[w] && i_wk_prd[w] == i_enq_prs[k][s]) w_enq_src_rdy[k][s] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
`ifdef IQ_WAKEUP_BYPASS_EN
      w_src_ok[i]   = r_rdy[i] | w_wk_src[i];
`else
      w_src_ok[i]   = r_rdy[i];
`endif
      o_req_vld[i]  = r_valid[i] & (&w_src_ok[i]);
      o_req_ages[i] = r_valid[i] ? r_rob[i] : '0;
    end
  end

  // Lower port wins a duplicate index; out-of-range or idle entries never fire.
  always_comb begin
    w_sel_req = '0;
    w_dup     = '0;
    w_fire    = '0;
    w_iss_clr = '0;
    for (int k = 0; k < OUTS; k++) begin
      for (int i = 0; i < DEPTH; i++)
        if (i_sel_idx[k] == IDX_W'(i) && o_req_vld[i]) w_sel_req[k] = 1'b1;
      for (int j = 0; j < OUTS; j++)
        if (j < k && w_fire[j] && i_sel_idx[j] == i_sel_idx[k]) w_dup[k] = 1'b1;
      w_fire[k] = i_sel_vld[k] & i_iss_rdy[k] & w_sel_req[k] & ~i_flush & ~w_dup[k];
      for (int i = 0; i < DEPTH; i++)
        if (w_fire[k] && i_sel_idx[k] == IDX_W'(i)) w_iss_clr[i] = 1'b1;
    end
  end

  always_comb begin
    w_valid_nxt = i_flush ? '0 : ((r_valid & ~w_iss_clr) | w_enq_we);
    w_pop       = '0;
    for (int i = 0; i < DEPTH; i++) w_pop = w_pop + CNT_W'(w_valid_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= '0;
      r_rdy      <= '0;
      r_free_cnt <= CNT_W'(DEPTH);
      r_iss_vld  <= '0;
    end else begin
      r_valid    <= w_valid_nxt;
      r_free_cnt <= CNT_W'(DEPTH) - w_pop;
      r_iss_vld  <= w_fire;
      for (int i = 0; i < DEPTH; i++) begin
        if (w_enq_we[i]) r_rdy[i] <= w_enq_src_rdy[w_enq_port[i]];
        else             r_rdy[i] <= r_rdy[i] | w_wk_src[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_enq_we[i]) begin
        r_rob[i] <= i_enq_robIdx[w_enq_port[i]];
        r_prs[i] <= i_enq_prs[w_enq_port[i]];
        r_pay[i] <= i_enq_payload[w_enq_port[i]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_iss_rob <= '0;
      r_iss_prs <= '0;
      r_iss_pay <= '0;
    end else begin
      for (int k = 0; k < OUTS; k++) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_fire[k] && i_sel_idx[k] == IDX_W'(i)) begin
            r_iss_rob[k] <= r_rob[i];
            r_iss_prs[k] <= r_prs[i];
            r_iss_pay[k] <= r_pay[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (w_pop <= CNT_W'(DEPTH));
      assert ((w_enq_we & r_valid) == '0);
      assert (!(|w_enq_go) || o_enq_rdy);
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: enqueue packing, wakeup timing, select/issue rules, flush and reset.
// Wakeup-timing expectations follow IQ_WAKEUP_BYPASS_EN when it is defined for the build.
module tb_issue_queue;
  logic                     clk = 1'b0;
  logic                     rst;
  logic                     i_flush;
  logic [1:0]               i_enq_vld;
  logic                     o_enq_rdy;
  logic [1:0][7:0]          i_enq_robIdx;
  logic [1:0][1:0][6:0]     i_enq_prs;
  logic [1:0][1:0]          i_enq_prs_rdy;
  logic [1:0][31:0]         i_enq_payload;
  logic [3:0]               i_wk_vld;
  logic [3:0][6:0]          i_wk_prd;
  logic [5:0]               o_req_vld;
  logic [5:0][7:0]          o_req_ages;
  logic [1:0]               i_sel_vld;
  logic [1:0][2:0]          i_sel_idx;
  logic [1:0]               i_iss_rdy;
  logic [1:0]               o_iss_vld;
  logic [1:0][7:0]          o_iss_robIdx;
  logic [1:0][1:0][6:0]     o_iss_prs;
  logic [1:0][31:0]         o_iss_payload;
  logic [2:0]               o_free_cnt;

  int n_pass = 0;
  int n_total = 0;

  issue_queue dut (
    .clk(clk), .rst(rst), .i_flush(i_flush),
    .i_enq_vld(i_enq_vld), .o_enq_rdy(o_enq_rdy), .i_enq_robIdx(i_enq_robIdx),
    .i_enq_prs(i_enq_prs), .i_enq_prs_rdy(i_enq_prs_rdy), .i_enq_payload(i_enq_payload),
    .i_wk_vld(i_wk_vld), .i_wk_prd(i_wk_prd),
    .o_req_vld(o_req_vld), .o_req_ages(o_req_ages),
    .i_sel_vld(i_sel_vld), .i_sel_idx(i_sel_idx), .i_iss_rdy(i_iss_rdy),
    .o_iss_vld(o_iss_vld), .o_iss_robIdx(o_iss_robIdx), .o_iss_prs(o_iss_prs),
    .o_iss_payload(o_iss_payload), .o_free_cnt(o_free_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle();
    i_flush = 0; i_enq_vld = '0; i_enq_robIdx = '0; i_enq_prs = '0; i_enq_prs_rdy = '0;
    i_enq_payload = '0; i_wk_vld = '0; i_wk_prd = '0; i_sel_vld = '0; i_sel_idx = '0;
    i_iss_rdy = '0;
  endtask

  task automatic enq(input int k, input logic [7:0] rob, input logic [6:0] p0, input logic [6:0] p1,
                     input logic [1:0] rdy, input logic [31:0] pay);
    i_enq_vld[k] = 1'b1; i_enq_robIdx[k] = rob; i_enq_prs[k][0] = p0; i_enq_prs[k][1] = p1;
    i_enq_prs_rdy[k] = rdy; i_enq_payload[k] = pay;
  endtask

  task automatic sel(input int k, input logic [2:0] idx, input logic rdy);
    i_sel_vld[k] = 1'b1; i_sel_idx[k] = idx; i_iss_rdy[k] = rdy;
  endtask

  // Advance one edge, drop all inputs, let combinational outputs settle.
  task automatic tick();
    @(posedge clk); #1; idle(); #1;
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    check("rst_free_cnt", o_free_cnt, 6);
    check("rst_iss_vld", o_iss_vld, 0);
    check("rst_req_vld", o_req_vld, 0);
    rst = 0;
    tick();
    check("rst_enq_rdy", o_enq_rdy, 1);

    // Two ready uops, then issue both
    enq(0, 8'd130, 7'd1, 7'd2, 2'b11, 32'hAAAA0001);
    enq(1, 8'd131, 7'd3, 7'd4, 2'b11, 32'hBBBB0002);
    tick();
    check("t1_req_vld", o_req_vld, 6'b000011);
    check("t1_age0", o_req_ages[0], 130);
    check("t1_age1", o_req_ages[1], 131);
    check("t1_free4", o_free_cnt, 4);
    sel(0, 3'd0, 1'b1); sel(1, 3'd1, 1'b1);
    tick();
    check("t1_iss_vld", o_iss_vld, 2'b11);
    check("t1_iss_rob0", o_iss_robIdx[0], 130);
    check("t1_iss_rob1", o_iss_robIdx[1], 131);
    check("t1_iss_prs01", o_iss_prs[0][1], 2);
    check("t1_iss_pay1", o_iss_payload[1], 32'hBBBB0002);
    check("t1_free6", o_free_cnt, 6);
    check("t1_req_empty", o_req_vld, 0);

    // Fill: port1 alone packs into entry 0
    enq(1, 8'd10, 7'd20, 7'd21, 2'b00, 32'h10);
    tick();
    check("t2_pack_age0", o_req_ages[0], 10);
    check("t2_free5", o_free_cnt, 5);
    check("t2_iss_idle", o_iss_vld, 0);
    enq(0, 8'd11, 7'd20, 7'd21, 2'b00, 32'h11);
    enq(1, 8'd12, 7'd20, 7'd21, 2'b00, 32'h12);
    tick();
    enq(0, 8'd13, 7'd20, 7'd21, 2'b00, 32'h13);
    enq(1, 8'd14, 7'd22, 7'd23, 2'b11, 32'h14);
    tick();
    check("t2_free1", o_free_cnt, 1);
    check("t2_enq_rdy0", o_enq_rdy, 0);
    check("t2_req_e4", o_req_vld, 6'b010000);
    enq(0, 8'd50, 7'd1, 7'd1, 2'b11, 32'h50);
    enq(1, 8'd51, 7'd1, 7'd1, 2'b11, 32'h51);
    sel(0, 3'd4, 1'b1);
    tick();
    check("t2_free2", o_free_cnt, 2);
    check("t2_enq_rdy1", o_enq_rdy, 1);
    check("t2_iss_vld", o_iss_vld, 2'b01);
    check("t2_iss_rob", o_iss_robIdx[0], 14);
    check("t2_ignored_e5", o_req_ages[5], 0);
    check("t2_freed_e4", o_req_ages[4], 0);
    i_flush = 1;
    tick();
    check("t2_flush_free", o_free_cnt, 6);

    // Stored entry waiting on prs 5
    enq(0, 8'd20, 7'd5, 7'd6, 2'b10, 32'h20);
    tick();
    check("t3_waiting", o_req_vld, 0);
    i_wk_vld[2] = 1; i_wk_prd[2] = 7'd5;
    #1;
`ifdef IQ_WAKEUP_BYPASS_EN
    check("t3_req_cycN", o_req_vld, 6'b000001);
`else
    check("t3_req_cycN", o_req_vld, 6'b000000);
`endif
    tick();
    check("t3_req_cycN1", o_req_vld, 6'b000001);

    // Enqueue racing its own wakeup
    enq(0, 8'd21, 7'd9, 7'd9, 2'b00, 32'h21);
    i_wk_vld[0] = 1; i_wk_prd[0] = 7'd9;
    tick();
    check("t4_req", o_req_vld, 6'b000011);
    check("t4_age1", o_req_ages[1], 21);

    // Duplicate select, blocked port, non-requesting select
    enq(0, 8'd22, 7'd1, 7'd1, 2'b11, 32'h22);
    enq(1, 8'd23, 7'd1, 7'd1, 2'b11, 32'h23);
    tick();
    check("t5_req4", o_req_vld, 6'b001111);
    sel(0, 3'd3, 1'b1); sel(1, 3'd3, 1'b1);
    tick();
    check("t5_dup_iss", o_iss_vld, 2'b01);
    check("t5_dup_rob", o_iss_robIdx[0], 23);
    check("t5_dup_req", o_req_vld, 6'b000111);
    check("t5_dup_free", o_free_cnt, 3);
    sel(0, 3'd2, 1'b0); sel(1, 3'd4, 1'b1);
    tick();
    check("t5_blocked_iss", o_iss_vld, 2'b00);
    check("t5_blocked_req", o_req_vld, 6'b000111);
    check("t5_blocked_free", o_free_cnt, 3);

    // Issue and enqueue in one cycle net out; enqueue takes the registered-free slot
    enq(0, 8'd24, 7'd1, 7'd1, 2'b11, 32'h24);
    sel(0, 3'd2, 1'b1);
    tick();
    check("t5_net_free", o_free_cnt, 3);
    check("t5_net_iss", o_iss_robIdx[0], 22);
    check("t5_net_age3", o_req_ages[3], 24);
    check("t5_net_age2", o_req_ages[2], 0);

    // Flush with 4 valid, 2 selected, enqueue pending
    enq(0, 8'd25, 7'd1, 7'd1, 2'b11, 32'h25);
    tick();
    check("t6_pre_req", o_req_vld, 6'b001111);
    i_flush = 1;
    sel(0, 3'd0, 1'b1); sel(1, 3'd1, 1'b1);
    enq(0, 8'd60, 7'd1, 7'd1, 2'b11, 32'h60);
    enq(1, 8'd61, 7'd1, 7'd1, 2'b11, 32'h61);
    tick();
    check("t6_iss_vld", o_iss_vld, 0);
    check("t6_req_vld", o_req_vld, 0);
    check("t6_free", o_free_cnt, 6);
    tick();
    check("t6_enq_dropped", o_req_vld, 0);

    // Reset mid-operation clears the issue registers too
    enq(0, 8'd40, 7'd1, 7'd1, 2'b11, 32'h40);
    tick();
    sel(0, 3'd0, 1'b1);
    tick();
    check("t7_iss_rob", o_iss_robIdx[0], 40);
    enq(0, 8'd41, 7'd1, 7'd1, 2'b11, 32'h41);
    rst = 1;
    tick();
    rst = 0;
    check("t7_rst_iss_vld", o_iss_vld, 0);
    check("t7_rst_iss_rob", o_iss_robIdx[0], 0);
    check("t7_rst_free", o_free_cnt, 6);
    check("t7_rst_req", o_req_vld, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
